// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: EX forwarding selects, stage stall/flush
// generation and the launch/hold sequencing for the multi-cycle divider.
module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       divE,
  input  logic       pcsrcM,
  input  logic       jumpM,
  input  logic       jrM,
  input  logic       jalM,
  input  logic       jalrM,
  input  logic       balM,
  input  logic       dmem_stall,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_start,
  output logic       div_busy
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            redir_m;
  logic            lwstall;
  logic            divhold;

  // M result is younger than W, so it wins when both match.
  always_comb begin
    forwardAE = 2'b00;
    if (regwriteM && (writeregM != 5'd0) && (writeregM == rsE)) begin
      forwardAE = 2'b10;
    end else if (regwriteW && (writeregW != 5'd0) && (writeregW == rsE)) begin
      forwardAE = 2'b01;
    end
    forwardBE = 2'b00;
    if (regwriteM && (writeregM != 5'd0) && (writeregM == rtE)) begin
      forwardBE = 2'b10;
    end else if (regwriteW && (writeregW != 5'd0) && (writeregW == rtE)) begin
      forwardBE = 2'b01;
    end
  end

  assign redir_m = pcsrcM | jumpM | jrM | jalM | jalrM | balM;
  assign lwstall = memtoregE & regwriteE & (writeregE != 5'd0) &
                   ((writeregE == rsD) | (writeregE == rtD));
  assign divhold = divE & (state_q != StDone);
  assign div_busy = (state_q != StIdle);

  // Divider sequencing; the counter keeps running through memory stalls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (divE) begin
          div_start = 1'b1;
          cnt_d     = CntW'(DIV_CYCLES - 1);
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (!dmem_stall) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pending redirect is held under a memory stall and taken once it clears.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      stallF = 1'b0;
    end else if (dmem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (redir_m) begin
      flushD = 1'b1;
      flushE = ~divhold;
      if (divhold) begin
        stallE = 1'b1;
        flushM = 1'b1;
      end
    end else if (divhold) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
    stallD = stallD & ~flushD;
    stallE = stallE & ~flushE;
    stallM = stallM & ~flushM;
    stallW = stallW & ~flushW;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational vectors plus hand-written
// divider, memory-stall and reset sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, divE;
  logic       pcsrcM, jumpM, jrM, jalM, jalrM, balM, dmem_stall;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW, div_start, div_busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [14:0] All    = 15'h7fff;
  localparam logic [14:0] NoBusy = 15'h7ffe;

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .divE(divE),
    .pcsrcM(pcsrcM), .jumpM(jumpM), .jrM(jrM), .jalM(jalM), .jalrM(jalrM), .balM(balM),
    .dmem_stall(dmem_stall),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_start(div_start), .div_busy(div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] out_vec;
  assign out_vec = {forwardAE, forwardBE, stallF, stallD, stallE, stallM, stallW,
                    flushD, flushE, flushM, flushW, div_start, div_busy};

  typedef struct {
    string       name;
    logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
    logic [3:0]  rw;     // {regwriteE, regwriteM, regwriteW, memtoregE}
    logic [5:0]  redir;  // {pcsrc, jump, jr, jal, jalr, bal}
    logic        dms;
    logic [14:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [14:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [4:0] st, input logic [3:0] fl,
                                     input logic ds, input logic db);
    return {fa, fb, st, fl, ds, db};
  endfunction

  function automatic vec_t mk(input string nm, input logic [4:0] rsd, input logic [4:0] rtd,
                              input logic [4:0] rse, input logic [4:0] rte,
                              input logic [4:0] wre, input logic [4:0] wrm,
                              input logic [4:0] wrw, input logic [3:0] rw,
                              input logic [5:0] redir, input logic dms,
                              input logic [14:0] exp);
    vec_t v;
    v.name = nm; v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw; v.rw = rw; v.redir = redir;
    v.dms = dms; v.exp = exp;
    return v;
  endfunction

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; divE = 0;
    pcsrcM = 0; jumpM = 0; jrM = 0; jalM = 0; jalrM = 0; balM = 0; dmem_stall = 0;
  endtask

  task automatic check(input string nm, input logic [14:0] exp, input logic [14:0] mask);
    n_tests++;
    if ((out_vec & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (mask %b)", nm, out_vec, exp, mask);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset must mask a div launch and a load-use hazard.
    divE = 1; rsD = 8; writeregE = 8; regwriteE = 1; memtoregE = 1;
    #2 check("rst_gating", ev(0, 0, 5'b00000, 4'b0000, 0, 0), NoBusy);
    @(negedge clk); #2 check("rst_state", ev(0, 0, 5'b00000, 4'b0000, 0, 0), All);
    @(negedge clk); rst = 1'b0; clear_inputs();
    #2 check("post_rst", ev(0, 0, 5'b00000, 4'b0000, 0, 0), All);

    vq.push_back(mk("idle", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b0, 0, ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwdA_M", 0, 0, 8, 0, 0, 8, 0, 4'b0100, 6'b0, 0,
                    ev(2'b10, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwdA_W", 0, 0, 8, 0, 0, 0, 8, 4'b0010, 6'b0, 0,
                    ev(2'b01, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwdA_Mprio", 0, 0, 8, 0, 0, 8, 8, 4'b0110, 6'b0, 0,
                    ev(2'b10, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwd_r0", 0, 0, 0, 0, 0, 0, 0, 4'b0110, 6'b0, 0, ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwdB_M_A_W", 0, 0, 10, 9, 0, 9, 10, 4'b0110, 6'b0, 0,
                    ev(2'b01, 2'b10, 0, 0, 0, 0)));
    vq.push_back(mk("fwd_noregwrite", 0, 0, 8, 8, 0, 8, 8, 4'b0000, 6'b0, 0,
                    ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("fwd_miss", 0, 0, 8, 8, 0, 7, 9, 4'b0110, 6'b0, 0, ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("lw_rs", 8, 0, 0, 0, 8, 0, 0, 4'b1001, 6'b0, 0,
                    ev(0, 0, 5'b11000, 4'b0100, 0, 0)));
    vq.push_back(mk("lw_rt", 3, 8, 0, 0, 8, 0, 0, 4'b1001, 6'b0, 0,
                    ev(0, 0, 5'b11000, 4'b0100, 0, 0)));
    vq.push_back(mk("lw_r0", 0, 0, 0, 0, 0, 0, 0, 4'b1001, 6'b0, 0, ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("alu_noload", 8, 0, 0, 0, 8, 0, 0, 4'b1000, 6'b0, 0,
                    ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("lw_noregwrite", 8, 0, 0, 0, 8, 0, 0, 4'b0001, 6'b0, 0,
                    ev(0, 0, 0, 0, 0, 0)));
    vq.push_back(mk("beq_taken", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b100000, 0,
                    ev(0, 0, 0, 4'b1100, 0, 0)));
    vq.push_back(mk("beq_lw_ignored", 8, 0, 0, 0, 8, 0, 0, 4'b1001, 6'b100000, 0,
                    ev(0, 0, 0, 4'b1100, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      vq.push_back(mk($sformatf("redir_src%0d", i), 0, 0, 0, 0, 0, 0, 0, 4'b0000,
                      6'b010000 >> i, 0, ev(0, 0, 0, 4'b1100, 0, 0)));
    end
    vq.push_back(mk("dmem", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b0, 1,
                    ev(0, 0, 5'b11110, 4'b0001, 0, 0)));
    vq.push_back(mk("dmem_redir_lw", 8, 0, 0, 0, 8, 0, 0, 4'b1001, 6'b100000, 1,
                    ev(0, 0, 5'b11110, 4'b0001, 0, 0)));
    vq.push_back(mk("dmem_fwd", 0, 0, 8, 0, 0, 8, 0, 4'b0100, 6'b0, 1,
                    ev(2'b10, 0, 5'b11110, 4'b0001, 0, 0)));

    foreach (vq[i]) begin
      @(negedge clk);
      rsD = vq[i].rsd; rtD = vq[i].rtd; rsE = vq[i].rse; rtE = vq[i].rte;
      writeregE = vq[i].wre; writeregM = vq[i].wrm; writeregW = vq[i].wrw;
      {regwriteE, regwriteM, regwriteW, memtoregE} = vq[i].rw;
      {pcsrcM, jumpM, jrM, jalM, jalrM, balM} = vq[i].redir;
      dmem_stall = vq[i].dms; divE = 1'b0;
      #2 check(vq[i].name, vq[i].exp, All);
    end

    // Divider, 4 cycles: issue + 4 busy cycles hold E, then DONE releases.
    @(negedge clk); clear_inputs(); divE = 1;
    #2 check("div_issue", ev(0, 0, 5'b11100, 4'b0010, 1, 0), All);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2 check("div_busy", ev(0, 0, 5'b11100, 4'b0010, 0, 1), All);
    end
    @(negedge clk); #2 check("div_done", ev(0, 0, 0, 0, 0, 1), All);
    @(negedge clk); divE = 0; #2 check("div_back_idle", ev(0, 0, 0, 0, 0, 0), All);

    // Divider launched under a memory stall: one pulse, counter runs, DONE waits.
    @(negedge clk); divE = 1; dmem_stall = 1;
    #2 check("divdm_issue", ev(0, 0, 5'b11110, 4'b0001, 1, 0), All);
    @(negedge clk); #2 check("divdm_no_2nd", ev(0, 0, 5'b11110, 4'b0001, 0, 1), All);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dmem_stall = 0;
      #2 check("divdm_busy", ev(0, 0, 5'b11100, 4'b0010, 0, 1), All);
    end
    @(negedge clk); dmem_stall = 1;
    #2 check("divdm_done_dm", ev(0, 0, 5'b11110, 4'b0001, 0, 1), All);
    @(negedge clk); dmem_stall = 0; #2 check("divdm_done", ev(0, 0, 0, 0, 0, 1), All);
    @(negedge clk); divE = 0; #2 check("divdm_idle", ev(0, 0, 0, 0, 0, 0), All);

    // Redirect held across 3 memory-stall cycles, then taken once.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); pcsrcM = 1; dmem_stall = 1;
      #2 check("dm_redir_hold", ev(0, 0, 5'b11110, 4'b0001, 0, 0), All);
    end
    @(negedge clk); dmem_stall = 0;
    #2 check("dm_redir_take", ev(0, 0, 0, 4'b1100, 0, 0), All);
    @(negedge clk); pcsrcM = 0; #2 check("dm_redir_after", ev(0, 0, 0, 0, 0, 0), All);

    // Redirect during divhold keeps the div in E, then reset mid-division.
    @(negedge clk); divE = 1; pcsrcM = 1;
    #2 check("div_redir_issue", ev(0, 0, 5'b00100, 4'b1010, 1, 0), All);
    @(negedge clk); pcsrcM = 0; jumpM = 1;
    #2 check("div_redir_busy", ev(0, 0, 5'b00100, 4'b1010, 0, 1), All);
    @(negedge clk); jumpM = 0;
    #2 check("div_busy2", ev(0, 0, 5'b11100, 4'b0010, 0, 1), All);
    @(negedge clk); rst = 1;
    #2 check("rst_mid_div", ev(0, 0, 0, 0, 0, 0), NoBusy);
    @(negedge clk); #2 check("rst_mid_div_next", ev(0, 0, 0, 0, 0, 0), All);
    @(negedge clk); rst = 0; divE = 0;
    #2 check("rst_release", ev(0, 0, 0, 0, 0, 0), All);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
